// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - shared encodings and level-count helper for the mux tree
package mux_tree_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int f_levels(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// rtl/mux_tree_stage.sv - one tree level: pairwise 2:1 select on tag bit BIT, then register
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int WIDTH = 8,
    parameter int SELW  = 1,
    parameter int BIT   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [N_IN*WIDTH-1:0]         i_data,
    input  logic [SELW-1:0]               i_tag,
    input  logic                          i_valid,
    input  logic                          i_scan,
    output logic [(N_IN/2)*WIDTH-1:0]     o_data,
    output logic [SELW-1:0]               o_tag,
    output logic                          o_valid,
    output logic                          o_scan
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] w_pick;
    logic [N_OUT*WIDTH-1:0] r_data;
    logic [SELW-1:0]        r_tag;
    logic                   r_valid;
    logic                   r_scan;

    // Tag bit set selects the odd member of each pair.
    always_comb begin
        w_pick = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_pick[j*WIDTH +: WIDTH] = i_tag[BIT] ? i_data[(2*j+1)*WIDTH +: WIDTH]
                                                  : i_data[(2*j)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_scan  <= 1'b0;
        end else if (en) begin
            r_data  <= w_pick;
            r_tag   <= i_tag;
            r_valid <= i_valid;
            r_scan  <= i_scan;
        end
    end

    assign o_data  = r_data;
    assign o_tag   = r_tag;
    assign o_valid = r_valid;
    assign o_scan  = r_scan;

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 channel mux tree with travelling tag and scan counter
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_sel,
    output logic                   out_valid,
    output logic                   out_last
);

    localparam int L  = f_levels(N_CH);
    localparam int DW = N_CH * WIDTH;

    logic [SELW-1:0] r_scan_cnt;
    logic            r_last;
    logic            w_scan_mode;

    // Level k feeds stage k; only the low (N_CH>>k)*WIDTH bits of each word are live.
    logic [DW-1:0]   w_data  [0:L];
    logic [SELW-1:0] w_tag   [0:L];
    logic            w_valid [0:L];
    logic            w_scan  [0:L];

    assign w_scan_mode = (mode == MODE_SCAN);
    assign w_data[0]   = in_data;
    assign w_tag[0]    = w_scan_mode ? r_scan_cnt : sel;
    assign w_valid[0]  = in_valid;
    assign w_scan[0]   = w_scan_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
        end else if (en) begin
            if (!w_scan_mode) begin
                r_scan_cnt <= '0;
            end else if (in_valid) begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NI = N_CH >> k;
        localparam int NO = NI / 2;

        mux_tree_stage #(
            .N_IN  (NI),
            .WIDTH (WIDTH),
            .SELW  (SELW),
            .BIT   (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .i_data  (w_data[k][NI*WIDTH-1:0]),
            .i_tag   (w_tag[k]),
            .i_valid (w_valid[k]),
            .i_scan  (w_scan[k]),
            .o_data  (w_data[k+1][NO*WIDTH-1:0]),
            .o_tag   (w_tag[k+1]),
            .o_valid (w_valid[k+1]),
            .o_scan  (w_scan[k+1])
        );

        assign w_data[k+1][DW-1:NO*WIDTH] = '0;
    end

    // Registered alongside the final stage so out_last lines up with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b0;
        end else if (en) begin
            r_last <= w_valid[L-1] & w_scan[L-1] & (w_tag[L-1] == SELW'(N_CH - 1));
        end
    end

    assign out_data  = w_data[L][WIDTH-1:0];
    assign out_sel   = w_tag[L];
    assign out_valid = w_valid[L];
    assign out_last  = r_last;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - directed and reference-model checks of mux_tree_pipe
module tb_mux_tree_pipe;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [127:0] in_data;
    logic         in_valid;
    logic         mode;
    logic [3:0]   sel;
    logic [7:0]   out_data;
    logic [3:0]   out_sel;
    logic         out_valid;
    logic         out_last;

    logic         c_mode;
    logic         c_valid;
    logic [1:0]   c2_data;
    logic [0:0]   c2_sel;
    logic [0:0]   c2_out_data;
    logic [0:0]   c2_out_sel;
    logic         c2_out_valid;
    logic         c2_out_last;
    logic [8191:0] c256_data;
    logic [7:0]   c256_sel;
    logic [31:0]  c256_out_data;
    logic [7:0]   c256_out_sel;
    logic         c256_out_valid;
    logic         c256_out_last;

    mux_tree_pipe #(.N_CH(16), .WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .mode(mode), .sel(sel), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_last(out_last)
    );

    mux_tree_pipe #(.N_CH(2), .WIDTH(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(c2_data), .in_valid(c_valid),
        .mode(c_mode), .sel(c2_sel), .out_data(c2_out_data), .out_sel(c2_out_sel),
        .out_valid(c2_out_valid), .out_last(c2_out_last)
    );

    mux_tree_pipe #(.N_CH(256), .WIDTH(32)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(c256_data), .in_valid(c_valid),
        .mode(c_mode), .sel(c256_sel), .out_data(c256_out_data), .out_sel(c256_out_sel),
        .out_valid(c256_out_valid), .out_last(c256_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] s;
        logic       last;
    } exp_t;

    exp_t       pipe [0:3];
    logic [3:0] scnt;
    int         n_vec;
    int         n_err;
    int         n_last;

    logic [0:0]  h2_d   [0:9999];
    logic [0:0]  h2_s   [0:9999];
    logic [31:0] h256_d [0:9999];
    logic [7:0]  h256_s [0:9999];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) pipe[i] = '{1'b0, 8'h00, 4'h0, 1'b0};
        scnt = 4'h0;
    endtask

    task automatic set_pattern();
        for (int c = 0; c < 16; c++) in_data[c*8 +: 8] = 8'h10 + 8'(c);
    endtask

    // Advance one clock on the 16:1 DUT, updating the expected pipeline first.
    task automatic step();
        exp_t       e;
        logic [3:0] s_eff;
        if (en) begin
            s_eff  = mode ? scnt : sel;
            e.v    = in_valid;
            e.d    = 8'h10 + 8'(s_eff);
            e.s    = s_eff;
            e.last = in_valid && mode && (s_eff == 4'd15);
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = e;
            if (!mode) scnt = 4'h0;
            else if (in_valid) scnt = 4'((scnt + 1) % 16);
        end
        @(posedge clk);
        #1;
        check("valid", out_valid, pipe[3].v);
        check("last", out_last, pipe[3].v && pipe[3].last);
        if (pipe[3].v) begin
            check("data", out_data, pipe[3].d);
            check("sel", out_sel, pipe[3].s);
        end
        if (out_last) n_last++;
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_last = 0;
        rst_n = 1'b1; en = 1'b1; in_valid = 1'b0; mode = 1'b0; sel = 4'h0;
        c_mode = 1'b0; c_valid = 1'b0; c2_data = '0; c2_sel = '0;
        c256_data = '0; c256_sel = '0;
        set_pattern();
        clear_model();

        #1 rst_n = 1'b0;
        #1;
        check("rst_data", out_data, 8'h00);
        check("rst_sel", out_sel, 4'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;

        // Single direct pulse on channel 5
        sel = 4'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Back-to-back direct stream
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Same stream with a 3-cycle stall and garbage inputs during it
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    in_data = {$urandom, $urandom, $urandom, $urandom};
                    sel = 4'($urandom); in_valid = 1'b1;
                    step();
                end
                set_pattern();
                en = 1'b1;
            end
            sel = 4'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Scan: 34 samples, two complete passes plus two
        n_last = 0;
        mode = 1'b1; in_valid = 1'b1; sel = 4'd9;
        for (int i = 0; i < 34; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("last_cnt", n_last, 2);

        // Leave scan, then re-enter: counter restarts at 0
        mode = 1'b0; in_valid = 1'b1;
        step(); step();
        mode = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Scan with alternating bubbles, then asynchronous reset mid-stream
        mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0);
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_last", out_last, 1'b0);
        clear_model();
        @(posedge clk); #3;
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        mode = 1'b0;

        // Parameter corners against a reference model, random select
        c_valid = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            c2_data = 2'($urandom);
            c2_sel  = 1'($urandom);
            for (int c = 0; c < 256; c++) c256_data[c*32 +: 32] = $urandom;
            c256_sel = 8'($urandom);
            h2_d[i]   = c2_data[c2_sel];
            h2_s[i]   = c2_sel;
            h256_d[i] = c256_data[c256_sel*32 +: 32];
            h256_s[i] = c256_sel;
            @(posedge clk);
            #1;
            check("n2_data", c2_out_data, h2_d[i]);
            check("n2_sel", c2_out_sel, h2_s[i]);
            check("n2_valid", c2_out_valid, 1'b1);
            check("n2_last", c2_out_last, 1'b0);
            if (i >= 7) begin
                check("n256_data", c256_out_data, h256_d[i-7]);
                check("n256_sel", c256_out_sel, h256_s[i-7]);
                check("n256_valid", c256_out_valid, 1'b1);
                check("n256_last", c256_out_last, 1'b0);
            end
        end
        c_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
